// File: rtl/player_control.sv
// player_control
//   Game-side consumer of the keyboard decoder's level outputs. Runs the
//   RUN / PAUSED / OVER state machine, divides inclock into a movement tick,
//   integrates left/right key levels into a clamped player position and
//   issues rate-limited fire pulses.
//
// Ports
//   inclock        system clock
//   resetn         asynchronous active-low reset
//   move_left      level, A key held
//   move_right     level, D key held
//   fire           level, Space held
//   pause          level, ESC held
//   game_over      level from collision logic, player destroyed
//   player_x       current player position (X_W bits)
//   fire_pulse     one-cycle shot request
//   restart_pulse  one-cycle request to clear the playfield
//   paused         high in PAUSED
//   over           high in OVER
//   tick           one-cycle strobe per movement tick (RUN only)
//   shot_count     shots fired since reset or restart, wraps at 256
module player_control #(
  parameter int TICK_DIV = 250000,
  parameter int X_W      = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 608,
  parameter int X_INIT   = 304,
  parameter int STEP     = 2,
  parameter int FIRE_CD  = 25
) (
  input  logic           inclock,
  input  logic           resetn,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           fire,
  input  logic           pause,
  input  logic           game_over,
  output logic [X_W-1:0] player_x,
  output logic           fire_pulse,
  output logic           restart_pulse,
  output logic           paused,
  output logic           over,
  output logic           tick,
  output logic [7:0]     shot_count
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (FIRE_CD > 0) ? $clog2(FIRE_CD + 1) : 1;

  typedef enum logic [1:0] {RUN, PAUSED, OVER} state_t;

  state_t          state, next_state;
  logic            pause_d, fire_d;
  logic            pause_edge, fire_edge;
  logic [TW-1:0]   tcnt, tcnt_next;
  logic [CW-1:0]   cd;
  logic            terminal, restart, tick_event, shoot;
  logic [X_W-1:0]  x_next;

  // The edge-detect registers reset to 1 so a key held through reset
  // is not seen as a fresh press.
  assign pause_edge = pause & ~pause_d;
  assign fire_edge  = fire & ~fire_d;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // game_over outranks a simultaneous pause press; pause presses are
  // ignored once the game is over.
  always_comb begin
    next_state = state;
    if (game_over && state != OVER) begin
      next_state = OVER;
    end else if (pause_edge && state == RUN) begin
      next_state = PAUSED;
    end else if (pause_edge && state == PAUSED) begin
      next_state = RUN;
    end else if (fire_edge && state == OVER) begin
      next_state = RUN;
    end
  end

  assign restart  = (state == OVER) && (next_state == RUN);
  assign terminal = (tcnt == TW'(TICK_DIV - 1));
  // A terminal count that coincides with a state change is swallowed.
  assign tick_event = (state == RUN) && terminal && (next_state == state);
  // The cooldown is tested before this tick's decrement, giving an
  // auto-fire period of FIRE_CD + 1 ticks.
  assign shoot = tick_event && fire && (cd == '0);

  always_comb begin
    tcnt_next = tcnt;
    if (restart) begin
      tcnt_next = '0;
    end else if (state == RUN) begin
      tcnt_next = terminal ? '0 : tcnt + TW'(1);
    end
  end

  // Clamp comparisons happen before the add/subtract so the unsigned
  // position never wraps.
  always_comb begin
    x_next = player_x;
    if (move_left && !move_right) begin
      if (int'(player_x) < X_MIN + STEP) begin
        x_next = X_W'(X_MIN);
      end else begin
        x_next = player_x - X_W'(STEP);
      end
    end else if (move_right && !move_left) begin
      if (int'(player_x) > X_MAX - STEP) begin
        x_next = X_W'(X_MAX);
      end else begin
        x_next = player_x + X_W'(STEP);
      end
    end
  end

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      pause_d       <= 1'b1;
      fire_d        <= 1'b1;
      tcnt          <= '0;
      cd            <= '0;
      player_x      <= X_W'(X_INIT);
      shot_count    <= 8'd0;
      tick          <= 1'b0;
      fire_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      pause_d       <= pause;
      fire_d        <= fire;
      tcnt          <= tcnt_next;
      tick          <= tick_event;
      fire_pulse    <= shoot;
      restart_pulse <= restart;
      if (restart) begin
        player_x   <= X_W'(X_INIT);
        cd         <= '0;
        shot_count <= 8'd0;
      end else if (tick_event) begin
        player_x <= x_next;
        if (shoot) begin
          cd         <= CW'(FIRE_CD);
          shot_count <= shot_count + 8'd1;
        end else if (cd != '0) begin
          cd <= cd - CW'(1);
        end
      end
    end
  end

  assign paused = (state == PAUSED);
  assign over   = (state == OVER);

endmodule

// File: tb/tb_player_control.sv
// tb_player_control
//   Directed testbench for player_control with a small configuration
//   (TICK_DIV=4, STEP=2, X_MIN=0, X_MAX=10, X_INIT=4, FIRE_CD=2).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_player_control;

  logic       inclock;
  logic       resetn;
  logic       move_left, move_right, fire, pause, game_over;
  logic [9:0] player_x;
  logic       fire_pulse, restart_pulse, paused, over, tick;
  logic [7:0] shot_count;

  int checks;
  int errors;

  player_control #(
    .TICK_DIV(4), .X_W(10), .X_MIN(0), .X_MAX(10),
    .X_INIT(4), .STEP(2), .FIRE_CD(2)
  ) dut (
    .inclock(inclock), .resetn(resetn),
    .move_left(move_left), .move_right(move_right),
    .fire(fire), .pause(pause), .game_over(game_over),
    .player_x(player_x), .fire_pulse(fire_pulse),
    .restart_pulse(restart_pulse), .paused(paused), .over(over),
    .tick(tick), .shot_count(shot_count)
  );

  initial inclock = 1'b0;
  always #5 inclock = ~inclock;

  // Advances to the next falling edge at which tick is high, with a bound.
  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge inclock);
      if (tick) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    move_left = 0; move_right = 0; fire = 0; pause = 0; game_over = 0;
    repeat (2) @(negedge inclock);
    checks++;
    if (player_x !== 10'd4 || shot_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: player_x=%0d shot_count=%0d expected 4/0", player_x, shot_count);
    end
    checks++;
    if ({fire_pulse, restart_pulse, tick, paused, over} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: fp/rp/tick/paused/over=%b expected 00000",
               {fire_pulse, restart_pulse, tick, paused, over});
    end
    resetn = 1'b1;
  endtask

  task automatic test_move;
    bit got;
    int exp_r[4] = '{6, 8, 10, 10};
    int exp_l[6] = '{8, 6, 4, 2, 0, 0};
    move_right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(got);
      checks++;
      if (!got || int'(player_x) != exp_r[i] || fire_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL move_right tick %0d: player_x=%0d fire_pulse=%b tick_seen=%b expected %0d/0/1",
                 i + 1, player_x, fire_pulse, got, exp_r[i]);
      end
    end
    move_right = 1'b0;
    move_left  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_tick(got);
      checks++;
      if (!got || int'(player_x) != exp_l[i]) begin
        errors++;
        $display("[TB] FAIL move_left tick %0d: player_x=%0d tick_seen=%b expected %0d",
                 i + 1, player_x, got, exp_l[i]);
      end
    end
    move_right = 1'b1;
    wait_tick(got);
    checks++;
    if (!got || player_x !== 10'd0) begin
      errors++;
      $display("[TB] FAIL move_both: player_x=%0d tick_seen=%b expected 0", player_x, got);
    end
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  task automatic test_fire;
    bit got;
    bit exp_fp;
    fire = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      wait_tick(got);
      exp_fp = (i == 1 || i == 4 || i == 7);
      checks++;
      if (!got || fire_pulse !== exp_fp) begin
        errors++;
        $display("[TB] FAIL autofire tick %0d: fire_pulse=%b tick_seen=%b expected %b", i, fire_pulse, got, exp_fp);
      end
    end
    checks++;
    if (shot_count !== 8'd3 || player_x !== 10'd0) begin
      errors++;
      $display("[TB] FAIL autofire_count: shot_count=%0d player_x=%0d expected 3/0", shot_count, player_x);
    end
    fire = 1'b0;
  endtask

  task automatic test_pause;
    bit got;
    bit bad;
    wait_tick(got);
    @(negedge inclock);
    pause = 1'b1;
    @(negedge inclock);
    checks++;
    if (!got || paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_enter: paused=%b tick_seen=%b expected 1", paused, got);
    end
    pause = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge inclock);
      if (paused !== 1'b1 || tick !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL pause_window: paused dropped or tick seen while paused (bad=%b expected 0)", bad);
    end
    pause = 1'b1;
    @(negedge inclock);
    checks++;
    if (paused !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_exit: paused=%b tick=%b expected 0/0", paused, tick);
    end
    pause = 1'b0;
    @(negedge inclock);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resume_early: tick=%b expected 0 one cycle after resume", tick);
    end
    @(negedge inclock);
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_tick: tick=%b expected 1 two cycles after resume", tick);
    end
  endtask

  task automatic test_game_over;
    bit got;
    logic [9:0] x_before;
    wait_tick(got);
    x_before = player_x;
    repeat (3) @(negedge inclock);
    // Next rising edge is a terminal count; collide it with a pause press.
    game_over  = 1'b1;
    pause      = 1'b1;
    move_right = 1'b1;
    @(negedge inclock);
    checks++;
    if (!got || over !== 1'b1 || paused !== 1'b0 || tick !== 1'b0 || player_x !== x_before) begin
      errors++;
      $display("[TB] FAIL game_over_entry: over=%b paused=%b tick=%b player_x=%0d expected 1/0/0/%0d",
               over, paused, tick, player_x, x_before);
    end
    game_over  = 1'b0;
    pause      = 1'b0;
    move_right = 1'b0;
    @(negedge inclock);
    pause = 1'b1;
    @(negedge inclock);
    pause = 1'b0;
    repeat (6) @(negedge inclock);
    checks++;
    if (over !== 1'b1 || paused !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL over_ignores_pause: over=%b paused=%b tick=%b expected 1/0/0", over, paused, tick);
    end
    fire = 1'b1;
    @(negedge inclock);
    checks++;
    if (restart_pulse !== 1'b1 || over !== 1'b0 || player_x !== 10'd4 || shot_count !== 8'd0 || fire_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart: rp=%b over=%b player_x=%0d shot_count=%0d fp=%b expected 1/0/4/0/0",
               restart_pulse, over, player_x, shot_count, fire_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge inclock);
      checks++;
      if (restart_pulse !== 1'b0 || fire_pulse !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_restart cycle %0d: rp=%b fp=%b tick=%b expected 0/0/0",
                 i + 1, restart_pulse, fire_pulse, tick);
      end
    end
    @(negedge inclock);
    checks++;
    if (tick !== 1'b1 || fire_pulse !== 1'b1 || shot_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL first_shot_after_restart: tick=%b fp=%b shot_count=%0d expected 1/1/1",
               tick, fire_pulse, shot_count);
    end
    fire = 1'b0;
  endtask

  task automatic test_reset_held;
    bit got;
    move_right = 1'b1;
    wait_tick(got);
    checks++;
    if (!got || player_x !== 10'd6) begin
      errors++;
      $display("[TB] FAIL pre_reset_move: player_x=%0d tick_seen=%b expected 6", player_x, got);
    end
    move_right = 1'b0;
    pause = 1'b1;
    fire  = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (player_x !== 10'd4 || shot_count !== 8'd0 || paused !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: player_x=%0d shot_count=%0d paused=%b tick=%b expected 4/0/0/0",
               player_x, shot_count, paused, tick);
    end
    repeat (3) @(negedge inclock);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge inclock);
      checks++;
      if (paused !== 1'b0 || over !== 1'b0 || restart_pulse !== 1'b0 || fire_pulse !== 1'b0 || tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL held_keys_after_reset cycle %0d: paused=%b over=%b rp=%b fp=%b tick=%b expected all 0",
                 i + 1, paused, over, restart_pulse, fire_pulse, tick);
      end
    end
    @(negedge inclock);
    checks++;
    if (tick !== 1'b1 || fire_pulse !== 1'b1 || shot_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL held_fire_first_tick: tick=%b fp=%b shot_count=%0d expected 1/1/1",
               tick, fire_pulse, shot_count);
    end
    pause = 1'b0;
  endtask

  // Continues from one shot already fired with fire still held.
  task automatic test_shot_wrap;
    int n;
    int cycles;
    n = 1;
    cycles = 0;
    while (n < 255 && cycles < 4000) begin
      @(negedge inclock);
      cycles++;
      if (fire_pulse) n++;
    end
    checks++;
    if (shot_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL shot_count_255: shot_count=%0d pulses_seen=%0d expected 255", shot_count, n);
    end
    cycles = 0;
    while (n < 256 && cycles < 100) begin
      @(negedge inclock);
      cycles++;
      if (fire_pulse) n++;
    end
    checks++;
    if (shot_count !== 8'd0 || n != 256) begin
      errors++;
      $display("[TB] FAIL shot_count_wrap: shot_count=%0d pulses_seen=%0d expected 0/256", shot_count, n);
    end
    fire = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_move;
    test_fire;
    test_pause;
    test_game_over;
    test_reset_held;
    test_shot_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
